mul4_product_accumulator: RTL and testbench
===========================================

# mul4_product_accumulator

Downstream stage of the 4x4 unsigned array multiplier. Consumes the registered 8-bit product stream and sums a programmed number of products into a wider accumulator. Presents the total on a valid/ready output handshake with a sticky overflow flag. Typical use is dot-product and MAC sequences built from repeated 4x4 multiplies.

## Interface
Parameters:
- ACC_W, 16, accumulator and result width in bits; must be >= 8.
- CNT_W, 4, width of the product-count field; at most 2^CNT_W-1 products per run.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new run; sampled only in IDLE.
- len  input  CNT_W  number of products in the run; sampled with start.
- p_in  input  8  unsigned product from the multiplier's P register.
- p_valid  input  1  p_in carries a new product this cycle. Driven by the multiplier's en delayed one cycle.
- busy  output  1  high in ACC and HOLD.
- sum  output  ACC_W  accumulated result; holds its value after the handshake.
- sum_valid  output  1  sum is final and awaiting consumption.
- sum_ready  input  1  consumer accepts sum.
- ovf  output  1  sticky: the run's accumulation carried out of ACC_W bits.

## Operation
FSM with states IDLE, ACC and HOLD. Reset puts the FSM in IDLE.

IDLE:
- start=1 and len!=0: clear acc and ovf, load remaining=len, go to ACC.
- start=1 and len=0: ignored; stay in IDLE, no output change.
- p_valid is ignored, including in the cycle where start is accepted. The first product can be accepted one cycle after start at the earliest.

ACC:
- Each cycle with p_valid=1: compute acc + zero-extended p_in in ACC_W+1 bits. The low ACC_W bits go to acc. Bit ACC_W ORs into ovf, so acc wraps modulo 2^ACC_W.
- remaining decrements on each accepted product.
- When p_valid=1 and remaining=1: load the final value into sum, drive sum_valid=1 and go to HOLD.
- p_valid=0: no change, with no timeout.
- start is ignored.

HOLD:
- sum_valid stays high and sum and ovf stay stable until sum_ready=1.
- On sum_valid & sum_ready: go to IDLE, and sum_valid falls on the next edge.
- p_valid and start are ignored. Products arriving in HOLD are dropped, and upstream must not issue them.

General rules:
- sum_ready is ignored when sum_valid=0.
- sum keeps its last value in IDLE; the next run overwrites it only on its final product.
- ovf keeps its last value in IDLE and is cleared only on the next accepted start.
- Reset mid-run (rst_n low in any state): the FSM goes immediately to IDLE, and acc, sum, remaining, ovf and sum_valid go to 0. Partial results are discarded.

## Timing
- Reset values: busy=0, sum=0, sum_valid=0, ovf=0. Internal acc=0, remaining=0.
- Throughput: one product per cycle in ACC.
- Latency: sum_valid is high on the edge that accepts the last product, i.e. visible in the next cycle. A run of N back-to-back products that starts at edge T (start accepted) gives sum_valid=1 after edge T+N.
- busy rises after the edge that accepts start. It falls after the handshake edge, together with sum_valid.
- Minimum gap: handshake edge, then one cycle in IDLE, then the next start can be accepted.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- Reset and idle: assert rst_n=0, then release. Drive p_valid=1 with p_in=8'hFF for 5 cycles with no start. Required: sum=0, sum_valid=0, busy=0, ovf=0 throughout.
- Basic run: start with len=3, then products 3*5=15, 15*15=225 and 2*7=14 on consecutive cycles. Required: sum_valid=1 with sum=254 one cycle after the third product and ovf=0. Holding sum_ready=0 for 4 cycles keeps sum=254. Raising sum_ready gives sum_valid=0 and busy=0 on the next cycle.
- Gapped input and ignored strobes:
  - start with len=2; p_valid pulses separated by 3 idle cycles, p_in=100 then 50; start pulses during ACC.
  - Required: sum=150; the extra starts have no effect.
  - Also: start with len=0 leaves busy=0.
- Overflow: build with ACC_W=10 and run len=5 with p_in=225 each (total 1125). Required: sum=1125-1024=101 and ovf=1. The next run with len=1 and p_in=4 gives sum=4 and ovf=0.
- Reset mid-run: start with len=4, accept two products of 200, then pulse rst_n low. Required: all outputs 0 immediately. A following run with len=1 and p_in=9 gives sum=9.
- Back-to-back runs: run len=15 with every product 225. Required: sum=3375 and ovf=0. Handshake, then start again in the cycle after the handshake. Required: the new run is accepted and the previous sum holds until its final product.

Source files
------------

// File: rtl/mul4_product_accumulator.sv
// Accumulates a programmed number of 8-bit products from the 4x4 multiplier
// into an ACC_W-bit total, presented on a valid/ready handshake with sticky overflow.
module mul4_product_accumulator #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [7:0]       p_in,
  input  logic             p_valid,
  output logic             busy,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [ACC_W:0]   acc_next;

  // One extra bit captures the carry that feeds the sticky overflow flag.
  assign acc_next = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, p_in};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          busy_d  = 1'b1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (p_valid) begin
          acc_d = acc_next[ACC_W-1:0];
          ovf_d = ovf_q | acc_next[ACC_W];
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            sum_d       = acc_next[ACC_W-1:0];
            sum_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        sum_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul4_product_accumulator.sv
// Directed bench for mul4_product_accumulator: a 16-bit and a 10-bit build
// share one stimulus stream and are checked against hand-computed values.
module tb_mul4_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  p_in;
  logic        p_valid;
  logic        sum_ready;

  logic        busy16, sum_valid16, ovf16;
  logic [15:0] sum16;
  logic        busy10, sum_valid10, ovf10;
  logic [9:0]  sum10;

  int unsigned nvec;
  int unsigned nfail;

  mul4_product_accumulator #(.ACC_W(16), .CNT_W(4)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_in      (p_in),
    .p_valid   (p_valid),
    .busy      (busy16),
    .sum       (sum16),
    .sum_valid (sum_valid16),
    .sum_ready (sum_ready),
    .ovf       (ovf16)
  );

  mul4_product_accumulator #(.ACC_W(10), .CNT_W(4)) u_dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_in      (p_in),
    .p_valid   (p_valid),
    .busy      (busy10),
    .sum       (sum10),
    .sum_valid (sum_valid10),
    .sum_ready (sum_ready),
    .ovf       (ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] v);
    p_valid = 1'b1;
    p_in    = v;
    step();
    p_valid = 1'b0;
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  initial begin
    nvec      = 0;
    nfail     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    p_in      = '0;
    p_valid   = 1'b0;
    sum_ready = 1'b0;

    // Reset and idle: products without start are ignored
    step();
    step();
    chk("rst_flags16", {busy16, sum_valid16, ovf16}, 3'b000);
    chk("rst_sum16", sum16, 0);
    chk("rst_flags10", {busy10, sum_valid10, ovf10}, 3'b000);
    chk("rst_sum10", sum10, 0);
    rst_n   = 1'b1;
    p_valid = 1'b1;
    p_in    = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_flags", {busy16, sum_valid16, ovf16}, 3'b000);
      chk("idle_sum", sum16, 0);
    end
    p_valid = 1'b0;
    step();

    // Basic run: 15 + 225 + 14 = 254
    do_start(3);
    chk("basic_busy", busy16, 1);
    chk("basic_sv_early", sum_valid16, 0);
    feed(8'd15);
    feed(8'd225);
    chk("basic_sv_mid", sum_valid16, 0);
    feed(8'd14);
    chk("basic_sv", sum_valid16, 1);
    chk("basic_sum", sum16, 254);
    chk("basic_ovf", ovf16, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("basic_hold_sv", sum_valid16, 1);
      chk("basic_hold_sum", sum16, 254);
    end
    handshake();
    chk("basic_done", {busy16, sum_valid16}, 2'b00);
    chk("basic_sum_kept", sum16, 254);
    step();

    // Gapped input with stray starts during ACC: 100 + 50 = 150
    do_start(2);
    feed(8'd100);
    start = 1'b1;
    len   = 4'd5;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gap_busy", busy16, 1);
    chk("gap_sv", sum_valid16, 0);
    feed(8'd50);
    chk("gap_sv_final", sum_valid16, 1);
    chk("gap_sum", sum16, 150);
    handshake();
    step();
    do_start(0);
    chk("len0_busy", busy16, 0);
    chk("len0_sv", sum_valid16, 0);
    chk("len0_sum", sum16, 150);

    // Overflow: 5 x 225 = 1125; 10-bit build wraps to 101
    do_start(5);
    for (int i = 0; i < 5; i++) feed(8'd225);
    chk("ovf_sum16", sum16, 1125);
    chk("ovf_flag16", ovf16, 0);
    chk("ovf_sv10", sum_valid10, 1);
    chk("ovf_sum10", sum10, 101);
    chk("ovf_flag10", ovf10, 1);
    handshake();
    chk("ovf_sticky_idle", ovf10, 1);
    do_start(1);
    chk("ovf_cleared", ovf10, 0);
    chk("ovf_sum_held", sum10, 101);
    feed(8'd4);
    chk("after_sum10", sum10, 4);
    chk("after_ovf10", ovf10, 0);
    chk("after_sum16", sum16, 4);
    handshake();
    step();

    // Reset mid-run clears everything asynchronously
    do_start(4);
    feed(8'd200);
    feed(8'd200);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {busy16, sum_valid16, ovf16}, 3'b000);
    chk("midrst_sum", sum16, 0);
    chk("midrst_sum10", sum10, 0);
    step();
    rst_n = 1'b1;
    step();
    do_start(1);
    feed(8'd9);
    chk("postrst_sv", sum_valid16, 1);
    chk("postrst_sum", sum16, 9);
    handshake();
    step();

    // Back-to-back: 15 x 225 = 3375 (10-bit: 303 with overflow)
    do_start(15);
    for (int i = 0; i < 15; i++) feed(8'd225);
    chk("b2b_sv", sum_valid16, 1);
    chk("b2b_sum16", sum16, 3375);
    chk("b2b_ovf16", ovf16, 0);
    chk("b2b_sum10", sum10, 303);
    chk("b2b_ovf10", ovf10, 1);
    handshake();
    do_start(2);
    chk("b2b_restart_busy", busy16, 1);
    chk("b2b_restart_sv", sum_valid16, 0);
    chk("b2b_hold_sum", sum16, 3375);
    feed(8'd10);
    chk("b2b_hold_sum2", sum16, 3375);
    feed(8'd20);
    chk("b2b2_sv", sum_valid16, 1);
    chk("b2b2_sum", sum16, 30);
    handshake();
    chk("final_idle", {busy16, sum_valid16}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
